// File: rtl/keypad_loader.sv
// Keypad front end for the mm:ss countdown timer: debounces a one-hot digit keypad and a clear key,
// then drives the timer's active-low load/clear strobes while tracking a shadow copy of its digits.
module keypad_loader #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] keys,
  input  logic       clear_key,
  input  logic       running,
  output logic [3:0] data,
  output logic       loadn,
  output logic       clearn,
  output logic       key_valid,
  output logic       key_error,
  output logic [1:0] digits,
  output logic [3:0] sh_us,
  output logic [3:0] sh_ds,
  output logic [3:0] sh_m
);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, ACT, WAIT_REL, REL_DEB} state_t;

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [10:0]      held, held_nx;
  logic [10:0]      sample;
  logic             single_key;
  logic             is_press;
  logic             released;
  logic [3:0]       held_bcd;

  // A clear combined with any digit, or two digits at once, is never a press.
  assign sample     = {clear_key, keys};
  assign single_key = (keys != '0) && ((keys & (keys - 10'd1)) == '0);
  assign is_press   = clear_key ? (keys == '0) : single_key;
  assign released   = (sample == '0);

  always_comb begin
    held_bcd = '0;
    for (int i = 0; i < 10; i++) begin
      if (held[i]) held_bcd = 4'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      held  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      held  <= held_nx;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_nx = state;
    cnt_nx   = cnt;
    held_nx  = held;
    case (state)
      IDLE: begin
        if (is_press) begin
          state_nx = DEBOUNCE;
          cnt_nx   = CNT_W'(1);
          held_nx  = sample;
        end
      end
      DEBOUNCE: begin
        if (cnt == CNT_DONE)    state_nx = ACT;
        else if (sample == held) cnt_nx  = cnt + CNT_W'(1);
        else                    state_nx = IDLE;
      end
      ACT: state_nx = WAIT_REL;
      WAIT_REL: begin
        if (released) begin
          state_nx = REL_DEB;
          cnt_nx   = CNT_W'(1);
        end
      end
      REL_DEB: begin
        if (cnt == CNT_DONE) state_nx = IDLE;
        else if (released)   cnt_nx   = cnt + CNT_W'(1);
        else                 state_nx = WAIT_REL;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The ACT cycle decides the action; strobes appear on the following cycle for exactly one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data      <= '0;
      loadn     <= 1'b1;
      clearn    <= 1'b1;
      key_valid <= 1'b0;
      key_error <= 1'b0;
      digits    <= '0;
      sh_us     <= '0;
      sh_ds     <= '0;
      sh_m      <= '0;
    end else begin
      loadn     <= 1'b1;
      clearn    <= 1'b1;
      key_valid <= 1'b0;
      key_error <= 1'b0;
      if (state == ACT) begin
        if (held[10]) begin
          clearn <= 1'b0;
          sh_us  <= '0;
          sh_ds  <= '0;
          sh_m   <= '0;
          digits <= '0;
        end else if (!running && sh_us <= 4'd5) begin
          data      <= held_bcd;
          loadn     <= 1'b0;
          key_valid <= 1'b1;
          // NOTE: non-blocking assignments make this a true shift; each shadow takes its neighbour's old value.
          sh_m      <= sh_ds;
          sh_ds     <= sh_us;
          sh_us     <= held_bcd;
          if (digits != 2'd3) digits <= digits + 2'd1;
        end else begin
          key_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_loader.sv
// Bench for keypad_loader: stimulus tables (directed and random) are scanned by a sample-history
// model to predict every output cycle, then replayed into the design and compared each cycle.
module tb_keypad_loader;

  localparam int N    = 4;
  localparam int MAXL = 1024;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] keys;
  logic       clear_key;
  logic       running;
  logic [3:0] data;
  logic       loadn, clearn, key_valid, key_error;
  logic [1:0] digits;
  logic [3:0] sh_us, sh_ds, sh_m;

  typedef struct packed {
    logic [3:0] data;
    logic       loadn;
    logic       clearn;
    logic       kv;
    logic       ke;
    logic [1:0] dig;
    logic [3:0] m;
    logic [3:0] ds;
    logic [3:0] us;
  } obs_t;

  localparam obs_t RESET_OBS = '{data: 4'd0, loadn: 1'b1, clearn: 1'b1, kv: 1'b0, ke: 1'b0,
                                 dig: 2'd0, m: 4'd0, ds: 4'd0, us: 4'd0};

  obs_t dut_obs;
  assign dut_obs = {data, loadn, clearn, key_valid, key_error, digits, sh_m, sh_ds, sh_us};

  keypad_loader #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .keys(keys), .clear_key(clear_key), .running(running),
    .data(data), .loadn(loadn), .clearn(clearn), .key_valid(key_valid), .key_error(key_error),
    .digits(digits), .sh_us(sh_us), .sh_ds(sh_ds), .sh_m(sh_m)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [9:0] sk [MAXL];
  logic       sc [MAXL];
  logic       sr [MAXL];
  int         act_code [MAXL];
  obs_t       expv [MAXL];
  obs_t       cap [MAXL];
  int         len;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic [9:0] k, input logic c, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      if (len < MAXL) begin
        sk[len] = k;
        sc[len] = c;
        sr[len] = r;
        len++;
      end
    end
  endtask

  task automatic press(input logic [9:0] k, input logic c, input logic r);
    add(k, c, r, N + 3);
    add(10'h000, 1'b0, r, N + 4);
  endtask

  function automatic logic is_press_at(input int t);
    return (sc[t] && sk[t] == '0) || (!sc[t] && $countones(sk[t]) == 1);
  endfunction

  function automatic logic rel_at(input int t);
    return !sc[t] && sk[t] == '0;
  endfunction

  function automatic logic [10:0] smp(input int t);
    return {sc[t], sk[t]};
  endfunction

  function automatic int code_at(input int t);
    if (sc[t]) return 10;
    for (int i = 0; i < 10; i++) if (sk[t][i]) return i;
    return -1;
  endfunction

  // Find accepted presses from the sample history: N identical press samples, one settling cycle,
  // then the action cycle; a press is re-armed only after N consecutive released samples plus one.
  task automatic build_model();
    int   t, t0, k, r, a, c;
    logic done;
    obs_t o;
    for (int i = 0; i < MAXL; i++) act_code[i] = -1;
    t = 0;
    while (t < len) begin
      if (!is_press_at(t)) begin
        t++;
        continue;
      end
      t0 = t;
      k  = 1;
      while (k < N && t0 + k < len && smp(t0 + k) == smp(t0)) k++;
      if (k < N) begin
        t = t0 + k + 1;
        continue;
      end
      a = t0 + N + 1;
      if (a < len) act_code[a] = code_at(t0);
      t    = a + 1;
      done = 1'b0;
      while (!done && t < len) begin
        while (t < len && !rel_at(t)) t++;
        r = t;
        k = 1;
        while (k < N && r + k < len && rel_at(r + k)) k++;
        if (k < N) t = r + k + 1;
        else begin
          t    = r + N + 1;
          done = 1'b1;
        end
      end
    end
    o = RESET_OBS;
    for (int i = 0; i < len; i++) begin
      o.loadn  = 1'b1;
      o.clearn = 1'b1;
      o.kv     = 1'b0;
      o.ke     = 1'b0;
      c = act_code[i];
      if (c == 10) begin
        o.clearn = 1'b0;
        o.m = '0; o.ds = '0; o.us = '0; o.dig = '0;
      end else if (c >= 0) begin
        if (!sr[i] && o.us <= 4'd5) begin
          o.data  = 4'(c);
          o.loadn = 1'b0;
          o.kv    = 1'b1;
          o.m     = o.ds;
          o.ds    = o.us;
          o.us    = 4'(c);
          o.dig   = (o.dig == 2'd3) ? 2'd3 : o.dig + 2'd1;
        end else begin
          o.ke = 1'b1;
        end
      end
      expv[i] = o;
    end
  endtask

  task automatic drive(input int t);
    keys      = sk[t];
    clear_key = sc[t];
    running   = sr[t];
  endtask

  task automatic run_segment();
    build_model();
    @(negedge clk);
    reset = 1'b1; keys = '0; clear_key = 1'b0; running = 1'b0;
    @(negedge clk);
    check("reset state", 32'(dut_obs), 32'(RESET_OBS));
    reset = 1'b0;
    drive(0);
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      cap[t] = dut_obs;
      check($sformatf("cycle %0d outputs", t), 32'(dut_obs), 32'(expv[t]));
      if (t + 1 < len) drive(t + 1);
    end
  endtask

  task automatic count_ev(input int lo, input int hi, output int nl, output int nc, output int nv, output int ne);
    nl = 0; nc = 0; nv = 0; ne = 0;
    for (int i = lo; i <= hi; i++) begin
      if (!cap[i].loadn)  nl++;
      if (!cap[i].clearn) nc++;
      if (cap[i].kv)      nv++;
      if (cap[i].ke)      ne++;
    end
  endtask

  task automatic gen_random();
    int         kind, nb;
    logic       r, c;
    logic [9:0] k;
    len = 0;
    while (len < 500) begin
      kind = int'($urandom_range(0, 9));
      r    = ($urandom_range(0, 4) == 0);
      c    = 1'b0;
      if (kind < 7) k = 10'd1 << $urandom_range(0, 9);
      else if (kind < 9) begin
        k = '0;
        c = 1'b1;
      end else begin
        k = 10'($urandom_range(1, 1023));
        c = 1'($urandom_range(0, 1));
      end
      nb = int'($urandom_range(0, 3));
      for (int b = 0; b < nb; b++) begin
        add(k, c, r, int'($urandom_range(1, 2)));
        add(10'h000, 1'b0, r, int'($urandom_range(1, 2)));
      end
      add(k, c, r, int'($urandom_range(2, 9)));
      if ($urandom_range(0, 2) == 0) add(k, c, ~r, int'($urandom_range(1, 3)));
      nb = int'($urandom_range(0, 2));
      for (int b = 0; b < nb; b++) begin
        add(10'h000, 1'b0, r, int'($urandom_range(1, 2)));
        add(k, c, r, 1);
      end
      add(10'h000, 1'b0, r, int'($urandom_range(2, 9)));
    end
  endtask

  initial begin
    int nl, nc, nv, ne;
    int m_130, m_7, m_5, m_multi, m_clr, m_run, m_late;
    int first, nstrobe;

    reset = 1'b1; keys = '0; clear_key = 1'b0; running = 1'b0;

    // Directed table: single press, bounce, digit shifting, rejections, invalid pattern, clear.
    len = 0;
    add(10'h008, 1'b0, 1'b0, 10);
    add(10'h000, 1'b0, 1'b0, 8);
    for (int i = 0; i < 3; i++) begin
      add(10'h004, 1'b0, 1'b0, 2);
      add(10'h000, 1'b0, 1'b0, 2);
    end
    add(10'h004, 1'b0, 1'b0, 8);
    add(10'h000, 1'b0, 1'b0, 8);
    press(10'h002, 1'b0, 1'b0);
    press(10'h008, 1'b0, 1'b0);
    press(10'h001, 1'b0, 1'b0);
    m_130 = len - 1;
    press(10'h080, 1'b0, 1'b0);
    m_7 = len - 1;
    press(10'h020, 1'b0, 1'b0);
    m_5 = len - 1;
    add(10'h011, 1'b0, 1'b0, 20);
    add(10'h000, 1'b0, 1'b0, 8);
    m_multi = len - 1;
    add(10'h000, 1'b1, 1'b0, 10);
    add(10'h000, 1'b0, 1'b0, 8);
    m_clr = len - 1;
    press(10'h004, 1'b0, 1'b1);
    m_run = len - 1;
    add(10'h010, 1'b0, 1'b1, 3);
    add(10'h010, 1'b0, 1'b0, 5);
    add(10'h000, 1'b0, 1'b0, 8);
    m_late = len - 1;
    run_segment();

    check("first strobe loadn", 32'(cap[5].loadn), 32'd0);
    check("first strobe data", 32'(cap[5].data), 32'd3);
    check("first strobe key_valid", 32'(cap[5].kv), 32'd1);
    check("first strobe sh_us", 32'(cap[5].us), 32'd3);
    check("first strobe digits", 32'(cap[5].dig), 32'd1);
    check("no early strobe", 32'(cap[4].loadn), 32'd1);
    count_ev(0, 17, nl, nc, nv, ne);
    check("one strobe while held", 32'(nl), 32'd1);
    count_ev(10, 34, nl, nc, nv, ne);
    check("no strobe while bouncing", 32'(nl), 32'd0);
    check("bounced key strobe", 32'({cap[35].loadn, cap[35].data}), 32'h02);
    check("after 1,3,0 shadows", 32'({cap[m_130].m, cap[m_130].ds, cap[m_130].us}), 32'h130);
    check("after 1,3,0 digits", 32'(cap[m_130].dig), 32'd3);
    check("4th digit shadows", 32'({cap[m_7].m, cap[m_7].ds, cap[m_7].us}), 32'h307);
    check("4th digit digits", 32'(cap[m_7].dig), 32'd3);
    count_ev(m_7 + 1, m_5, nl, nc, nv, ne);
    check("tens>5 key_error", 32'(ne), 32'd1);
    check("tens>5 no strobe", 32'(nl), 32'd0);
    check("tens>5 shadows kept", 32'({cap[m_5].m, cap[m_5].ds, cap[m_5].us}), 32'h307);
    count_ev(m_5 + 1, m_multi, nl, nc, nv, ne);
    check("two keys no action", 32'(nl + nc + ne), 32'd0);
    count_ev(m_multi + 1, m_clr, nl, nc, nv, ne);
    check("clear strobe count", 32'(nc), 32'd1);
    check("clear zeroes shadows", 32'({cap[m_clr].m, cap[m_clr].ds, cap[m_clr].us, 2'b00, cap[m_clr].dig}), 32'd0);
    count_ev(m_clr + 1, m_run, nl, nc, nv, ne);
    check("running key_error", 32'(ne), 32'd1);
    check("running no strobe", 32'(nl), 32'd0);
    count_ev(m_run + 1, m_late, nl, nc, nv, ne);
    check("running drop in debounce ignored", 32'(nv), 32'd1);
    check("late accept sh_us", 32'(cap[m_late].us), 32'd4);

    // Reset during the strobe of a held digit, then a fresh debounce with the key still down.
    @(negedge clk);
    reset = 1'b1; keys = 10'h040; clear_key = 1'b0; running = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("strobe before reset", 32'({loadn, key_valid, data}), 32'h016);
    reset = 1'b1;
    #1;
    check("async reset mid-strobe", 32'(dut_obs), 32'(RESET_OBS));
    @(negedge clk);
    reset = 1'b0;
    first   = -1;
    nstrobe = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!loadn) begin
        nstrobe++;
        if (first < 0) first = t;
      end
    end
    check("fresh debounce latency", 32'(first), 32'd5);
    check("one accept after reset", 32'(nstrobe), 32'd1);

    for (int s = 0; s < 4; s++) begin
      gen_random();
      run_segment();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_loader.md
Name: keypad_loader

Overview:
- Front-end producer for the mm:ss countdown timer's parallel-load interface.
- Debounces a raw 10-key one-hot keypad plus a clear key and encodes each accepted key to BCD.
- Drives the timer's active-low load and clear inputs so that each accepted digit shifts into the timer: units takes the new digit, tens takes the old units, minutes takes the old tens.
- Keeps a shadow copy of the timer digits so that entries making tens-of-seconds greater than 5 are rejected.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a press or a release (minimum 2)
CNT_W, 5, width of the debounce counter (must hold DEBOUNCE_CYCLES)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
keys  input  10  raw keypad, bit n = digit n pressed (active-high, may bounce)
clear_key  input  1  raw clear key (active-high, may bounce)
running  input  1  high while the timer counts down; digit entry is blocked
data  output  4  BCD digit presented to the timer load input
loadn  output  1  active-low, one-cycle load strobe to the timer
clearn  output  1  active-low, one-cycle clear strobe to the timer
key_valid  output  1  one-cycle pulse when a digit is accepted
key_error  output  1  one-cycle pulse when a stable digit press is rejected
digits  output  2  digits entered since the last clear, saturates at 3
sh_us, sh_ds, sh_m  output  4 each  shadow of timer units, tens and minutes

Behaviour:
- Reset values: data=0, loadn=1, clearn=1, key_valid=0, key_error=0, digits=0, all shadows=0, FSM in IDLE, debounce counter 0. Reset asserted mid-strobe forces loadn and clearn high immediately.
- All outputs are registered.
- Input sample:
  - "Press" = clear_key=1, or exactly one bit of keys set with clear_key=0.
  - "Released" = keys==0 and clear_key==0.
  - Any other pattern (two or more keys, or clear plus digit) is treated as no press: it restarts the debounce and never reaches an accept.
  - If clear_key=1 together with digit keys, the sample is invalid; no action is taken.
- FSM states:
  - IDLE: a press is seen → DEBOUNCE; latch the sample and set the counter to 1.
  - DEBOUNCE:
    - Sample equals the latched sample: increment the counter.
    - Sample differs: return to IDLE.
    - Counter reaches DEBOUNCE_CYCLES: go to ACT.
  - ACT (one cycle):
    - Clear sample: clearn=0 for this cycle; shadows and digits go to 0. Clear is honoured even while running.
    - Digit d, with running=0 and sh_us<=5: data=d, loadn=0, key_valid=1. Shadow shift: sh_m<=sh_ds, sh_ds<=sh_us, sh_us<=d. digits<=min(digits+1,3).
    - Digit with running=1 or sh_us>5: key_error=1; no strobe; shadows unchanged.
    - Next state: WAIT_REL.
  - WAIT_REL: Released → REL_DEB with counter 1; otherwise stay.
  - REL_DEB:
    - Released: increment the counter; at DEBOUNCE_CYCLES go to IDLE.
    - Any non-released sample: back to WAIT_REL.
- Exactly one action per physical press, however long the key is held. Latency from the first stable sample to the strobe is DEBOUNCE_CYCLES+1 cycles.
- data holds its last driven value between strobes. loadn and clearn are never low in the same cycle.
- Digit count saturation: a 4th and later digit still loads and shifts (old minutes is discarded, matching the timer); digits stays 3.
- A change of running during DEBOUNCE has no effect; running is sampled only in ACT.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then keys=0x008 held 10 cycles → loadn low for exactly 1 cycle, 5 cycles after the first sample, with data=3, key_valid=1, sh_us=3, digits=1; no second strobe while still held.
- keys toggles 0x004/0x000 every 2 cycles, then holds 0x004 → a single accept (data=2) only after 4 stable cycles; no strobe during bouncing.
- Enter 1,3,0 with full press/release → three strobes, sh_m=1, sh_ds=3, sh_us=0, digits=3; then press 7 → sh_m=3, sh_ds=0, sh_us=7, digits=3.
- sh_us=7, press 5 → key_error pulse, loadn stays 1, shadows unchanged. With running=1, press 2 → key_error, no strobe.
- keys=0x011 held 20 cycles → no strobe, no error. clear_key held → clearn low 1 cycle, shadows 0, digits 0.
- Assert reset during ACT of a digit press → loadn=1 and all outputs return to reset values asynchronously; after reset is released with the key still held, one accept occurs after a fresh debounce.
